disp_scan: RTL and testbench

DISP_SCAN -- requirements
Module: disp_scan

---
 rtl/disp_scan.sv | 134 +++++++++++++
 tb/tb_disp_scan.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/disp_scan.sv
// Eight-digit multiplexed seven-segment scanner with a per-frame input snapshot.
// Optional macro LEADING_ZERO_BLANK_EN suppresses leading zeros (digit 0 always shown).
module disp_scan #(
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic       clkm,
  input  logic       rstn,
  input  logic       en,
  input  logic [3:0] Din0,
  input  logic [3:0] Din1,
  input  logic [3:0] Din2,
  input  logic [3:0] Din3,
  input  logic [3:0] Din4,
  input  logic [3:0] Din5,
  input  logic [3:0] Din6,
  input  logic [3:0] Din7,
  output logic [7:0] Sel,
  output logic [6:0] Seg
);

  localparam int unsigned CntW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(SCAN_DIV - 1);

  localparam logic [7:0] SelOff = 8'hFF;
  localparam logic [6:0] SegOff = 7'h7F;
  localparam logic [3:0] CodeBlank = 4'd10;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [3:0]      snap_q [8];
  logic [3:0]      snap_d [8];
  logic [3:0]      din    [8];
  logic [7:0]      sel_q, sel_d;
  logic [6:0]      seg_q, seg_d;
  logic [7:0]      lz_blank;
  logic            frame_start;
  logic            slot_end;

  function automatic logic [6:0] seg_decode(input logic [3:0] code);
    logic [6:0] seg;
    case (code)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = SegOff;
    endcase
    return seg;
  endfunction

  always_comb begin
    din[0] = Din0;
    din[1] = Din1;
    din[2] = Din2;
    din[3] = Din3;
    din[4] = Din4;
    din[5] = Din5;
    din[6] = Din6;
    din[7] = Din7;
  end

  // Scan position and frame snapshot; everything freezes while en is low.
  always_comb begin
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    snap_d      = snap_q;
    frame_start = en && (cnt_q == '0) && (idx_q == 3'd0);
    slot_end    = en && (cnt_q == CntMax);
    if (frame_start) begin
      snap_d = din;
    end
    if (en) begin
      if (slot_end) begin
        cnt_d = '0;
        idx_d = idx_q + 3'd1;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // A zero is blanked while every digit to its left is zero or already blank.
  always_comb begin
    logic higher_dark;
    lz_blank    = '0;
    higher_dark = 1'b1;
    for (int k = 7; k >= 1; k--) begin
      lz_blank[k] = (snap_q[k] == 4'd0) && higher_dark;
      higher_dark = higher_dark && ((snap_q[k] == 4'd0) || (snap_q[k] >= 4'd10));
    end
  end
`else
  assign lz_blank = '0;
`endif

  // cnt == 0 is the dead slot between digits that prevents ghosting.
  always_comb begin
    sel_d = SelOff;
    seg_d = SegOff;
    if (en && (cnt_q != '0)) begin
      sel_d = ~(8'd1 << idx_q);
      seg_d = lz_blank[idx_q] ? SegOff : seg_decode(snap_q[idx_q]);
    end
  end

  always_ff @(posedge clkm or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
      idx_q <= 3'd0;
      sel_q <= SelOff;
      seg_q <= SegOff;
      for (int k = 0; k < 8; k++) begin
        snap_q[k] <= CodeBlank;
      end
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      sel_q  <= sel_d;
      seg_q  <= seg_d;
      snap_q <= snap_d;
    end
  end

  assign Sel = sel_q;
  assign Seg = seg_q;

endmodule

// File: tb/tb_disp_scan.sv
// Bench for disp_scan: SCAN_DIV=4 and SCAN_DIV=2 instances against an arithmetic scan model.
module tb_disp_scan;

  logic       clkm;
  logic       rstn;
  logic       en;
  logic [3:0] din [8];
  logic [7:0] sel_a, sel_b;
  logic [6:0] seg_a, seg_b;

  int checks = 0;
  int errors = 0;
  bit mon_on = 0;

  disp_scan #(.SCAN_DIV(4)) dut (
    .clkm(clkm), .rstn(rstn), .en(en),
    .Din0(din[0]), .Din1(din[1]), .Din2(din[2]), .Din3(din[3]),
    .Din4(din[4]), .Din5(din[5]), .Din6(din[6]), .Din7(din[7]),
    .Sel(sel_a), .Seg(seg_a)
  );

  disp_scan #(.SCAN_DIV(2)) dut2 (
    .clkm(clkm), .rstn(rstn), .en(en),
    .Din0(din[0]), .Din1(din[1]), .Din2(din[2]), .Din3(din[3]),
    .Din4(din[4]), .Din5(din[5]), .Din6(din[6]), .Din7(din[7]),
    .Sel(sel_b), .Seg(seg_b)
  );

  initial clkm = 1'b0;
  always #5 clkm = ~clkm;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: n counts enabled cycles since reset; slot and phase follow by division.
  int unsigned n [2];
  logic [3:0]  snap [2][8];
  logic [7:0]  esel [2];
  logic [6:0]  eseg [2];
  int          eslot [2];
  int          eph [2];

  function automatic int unsigned div_of(input int i);
    return (i == 0) ? 4 : 2;
  endfunction

  function automatic int slot_of(input int i);
    return int'((n[i] / div_of(i)) % 8);
  endfunction

  function automatic int ph_of(input int i);
    return int'(n[i] % div_of(i));
  endfunction

  function automatic logic [6:0] dec(input logic [3:0] c);
    logic [6:0] t [16];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
          7'h00, 7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    return t[c];
  endfunction

  function automatic logic [6:0] model_seg(input int i, input int d);
    bit blank;
    blank = 0;
`ifdef LEADING_ZERO_BLANK_EN
    if (snap[i][d] == 4'd0 && d != 0) begin
      blank = 1;
      for (int j = d + 1; j < 8; j++)
        if (!(snap[i][j] == 4'd0 || snap[i][j] >= 4'd10)) blank = 0;
    end
`endif
    return blank ? 7'h7F : dec(snap[i][d]);
  endfunction

  always @(posedge clkm or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 2; i++) begin
        n[i]     <= 0;
        esel[i]  <= 8'hFF;
        eseg[i]  <= 7'h7F;
        eslot[i] <= -1;
        eph[i]   <= -1;
        for (int k = 0; k < 8; k++) snap[i][k] <= 4'd10;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (en && ph_of(i) != 0) begin
          esel[i]  <= ~(8'd1 << slot_of(i));
          eseg[i]  <= model_seg(i, slot_of(i));
          eslot[i] <= slot_of(i);
          eph[i]   <= ph_of(i);
        end else begin
          esel[i]  <= 8'hFF;
          eseg[i]  <= 7'h7F;
          eslot[i] <= -1;
          eph[i]   <= -1;
        end
        if (en) begin
          if (n[i] % (8 * div_of(i)) == 0)
            for (int k = 0; k < 8; k++) snap[i][k] <= din[k];
          n[i] <= n[i] + 1;
        end
      end
    end
  end

  always @(negedge clkm) begin
    if (mon_on) begin
      chk("mon_sel_div4", sel_a, esel[0]);
      chk("mon_seg_div4", seg_a, eseg[0]);
      chk("mon_sel_div2", sel_b, esel[1]);
      chk("mon_seg_div2", seg_b, eseg[1]);
      chk("onehot_div4", ($countones(~sel_a) <= 1), 1);
      chk("onehot_div2", ($countones(~sel_b) <= 1), 1);
    end
  end

  // Waits until the DIV=4 output shows the given slot/phase; returns cycles waited.
  task automatic wait_slot(input int s, input int ph, output int waited);
    bit hit;
    hit = 0;
    waited = 0;
    while (!hit && waited < 300) begin
      @(negedge clkm);
      waited++;
      hit = (eslot[0] == s) && (eph[0] == ph);
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("FAIL wait_slot: slot %0d phase %0d not reached within %0d cycles", s, ph, waited);
    end
  endtask

  typedef struct {
    logic [3:0] code;
    logic [7:0] sel;
    logic [6:0] seg;
  } vec_t;

  vec_t vecs [16];
  logic [7:0] seq_sel [12];
  logic [6:0] seq_seg [12];

  initial begin
    int w;
    int stamps [4];
    int nst;
    int lows;
    int falls;
    logic prev0;
    logic prev3;

    vecs = '{
      '{4'h0, 8'hFE, 7'h40}, '{4'h1, 8'hFE, 7'h79}, '{4'h2, 8'hFE, 7'h24},
      '{4'h3, 8'hFE, 7'h30}, '{4'h4, 8'hFE, 7'h19}, '{4'h5, 8'hFE, 7'h12},
      '{4'h6, 8'hFE, 7'h02}, '{4'h7, 8'hFE, 7'h78}, '{4'h8, 8'hFE, 7'h00},
      '{4'h9, 8'hFE, 7'h10}, '{4'hA, 8'hFE, 7'h7F}, '{4'hB, 8'hFE, 7'h7F},
      '{4'hC, 8'hFE, 7'h7F}, '{4'hD, 8'hFE, 7'h7F}, '{4'hE, 8'hFE, 7'h7F},
      '{4'hF, 8'hFE, 7'h7F}
    };
    seq_sel = '{8'hFF, 8'hFE, 8'hFE, 8'hFE, 8'hFF, 8'hFD, 8'hFD, 8'hFD,
                8'hFF, 8'hFB, 8'hFB, 8'hFB};
    seq_seg = '{7'h7F, 7'h40, 7'h40, 7'h40, 7'h7F, 7'h79, 7'h79, 7'h79,
                7'h7F, 7'h24, 7'h24, 7'h24};

    rstn = 1'b1;
    en   = 1'b0;
    for (int k = 0; k < 8; k++) din[k] = 4'd0;
    #1 rstn = 1'b0;
    #2 mon_on = 1;

    // Reset state
    @(negedge clkm);
    chk("reset_sel", sel_a, 8'hFF);
    chk("reset_seg", seg_a, 7'h7F);
    chk("reset_sel_div2", sel_b, 8'hFF);
    for (int k = 0; k < 8; k++) din[k] = 4'(k);
    en = 1'b1;
    @(negedge clkm);
    rstn = 1'b1;

    // First slots after reset
    for (int k = 0; k < 12; k++) begin
      @(negedge clkm);
      chk($sformatf("seq_sel_%0d", k), sel_a, seq_sel[k]);
      chk($sformatf("seq_seg_%0d", k), seg_a, seq_seg[k]);
    end

    // Din change mid-frame only shows in the following frame
    wait_slot(1, 2, w);
    din[3] = 4'd8;
    wait_slot(3, 1, w);
    chk("din3_this_frame", seg_a, 7'h30);
    wait_slot(3, 1, w);
    chk("din3_next_frame", seg_a, 7'h00);

    // Pause at idx=5 cnt=2
    wait_slot(5, 1, w);
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clkm);
      chk("pause_sel", sel_a, 8'hFF);
      chk("pause_seg", seg_a, 7'h7F);
    end
    en = 1'b1;
    @(negedge clkm);
    chk("resume_sel", sel_a, 8'hDF);
    chk("resume_seg", seg_a, 7'h12);

    // Asynchronous reset during idx=6
    wait_slot(6, 2, w);
    #2 rstn = 1'b0;
    #1;
    chk("async_rst_sel", sel_a, 8'hFF);
    chk("async_rst_seg", seg_a, 7'h7F);
    chk("async_rst_sel_div2", sel_b, 8'hFF);
    din[0] = 4'd9;
    din[6] = 4'd2;
    @(negedge clkm);
    @(negedge clkm);
    rstn = 1'b1;
    wait_slot(0, 1, w);
    chk("post_rst_latency", w, 2);
    chk("post_rst_sel", sel_a, 8'hFE);
    chk("post_rst_seg", seg_a, 7'h10);
    wait_slot(6, 1, w);
    chk("post_rst_digit6", seg_a, 7'h24);

    // Leading-zero pattern
    din[7] = 4'hA; din[6] = 4'h0; din[5] = 4'h0; din[4] = 4'h1;
    din[3] = 4'h0; din[2] = 4'h2; din[1] = 4'h3; din[0] = 4'h4;
    wait_slot(7, 3, w);
    wait_slot(3, 1, w);
    chk("lz_digit3", seg_a, 7'h40);
    wait_slot(5, 1, w);
`ifdef LEADING_ZERO_BLANK_EN
    chk("lz_digit5", seg_a, 7'h7F);
`else
    chk("lz_digit5", seg_a, 7'h40);
`endif
    wait_slot(6, 1, w);
`ifdef LEADING_ZERO_BLANK_EN
    chk("lz_digit6", seg_a, 7'h7F);
`else
    chk("lz_digit6", seg_a, 7'h40);
`endif
    wait_slot(7, 1, w);
    chk("lz_digit7", seg_a, 7'h7F);

    // Decode table on digit 0
    for (int v = 0; v < 16; v++) begin
      din[0] = vecs[v].code;
      wait_slot(7, 3, w);
      wait_slot(0, 1, w);
      chk($sformatf("dec_sel_%0h", vecs[v].code), sel_a, vecs[v].sel);
      chk($sformatf("dec_seg_%0h", vecs[v].code), seg_a, vecs[v].seg);
    end

    // Random frames, model-checked by the monitor
    for (int f = 0; f < 4; f++) begin
      for (int k = 0; k < 8; k++) din[k] = 4'($urandom_range(0, 15));
      wait_slot(7, 3, w);
    end

    // Frame period from Sel[0] falling edges
    nst = 0;
    prev0 = sel_a[0];
    for (int c = 0; c < 200 && nst < 4; c++) begin
      @(negedge clkm);
      if (prev0 && !sel_a[0]) begin
        stamps[nst] = c;
        nst++;
      end
      prev0 = sel_a[0];
      if (c % 8 == 0) din[$urandom_range(0, 7)] = 4'($urandom_range(0, 15));
    end
    chk("period_edges_found", nst, 4);
    if (nst == 4)
      for (int k = 1; k < 4; k++) chk("frame_period", stamps[k] - stamps[k-1], 32);

    // SCAN_DIV=2: digit 3 lit one cycle per 16-cycle frame
    lows  = 0;
    falls = 0;
    prev3 = sel_b[3];
    for (int c = 0; c < 48; c++) begin
      @(negedge clkm);
      if (!sel_b[3]) lows++;
      if (prev3 && !sel_b[3]) falls++;
      prev3 = sel_b[3];
    end
    chk("div2_lit_cycles", lows, 3);
    chk("div2_lit_runs", falls, 3);

    mon_on = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
